headgen_seq_ctrl: RTL and testbench

HEADGEN_SEQ_CTRL -- requirements
Module: headgen_seq_ctrl

---
 rtl/headgen_seq_ctrl_pkg.sv | 29 ++
 rtl/headgen_ucode_rom.sv | 25 ++
 rtl/headgen_seq_ctrl.sv | 94 +++++++++
 tb/tb_headgen_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/headgen_seq_ctrl_pkg.sv
// Shared definitions for the header-generator sequencer: FSM encoding,
// default geometry and the microcode word layout/contents.
package headgen_seq_ctrl_pkg;

  localparam int HDR_LEN_DEF = 42;
  localparam int UADDR_W_DEF = 6;
  localparam int UWORD_W     = 9;
  localparam int UDYN_BIT    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Words 12..15 select a dynamic byte (low bits pick dyn0/dyn1 hi/lo);
  // every other word carries a constant header byte.
  function automatic logic [UWORD_W-1:0] ucode_word(input logic [7:0] a);
    logic [UWORD_W-1:0] w;
    w = {1'b0, a * 8'd5 + 8'h11};
    if (a[7:2] == 6'd3) begin
      w           = '0;
      w[UDYN_BIT] = 1'b1;
      w[1:0]      = a[1:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/headgen_ucode_rom.sv
// Microcode ROM for the header generator: array contents from the package,
// registered read with one cycle of latency.
module headgen_ucode_rom
  import headgen_seq_ctrl_pkg::*;
#(
  parameter int UADDR_W = UADDR_W_DEF
) (
  input  logic               clk,
  input  logic [UADDR_W-1:0] addr,
  output logic [UWORD_W-1:0] data
);

  localparam int DEPTH = 1 << UADDR_W;

  logic [UWORD_W-1:0] rom_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_mem[gi] = ucode_word(8'(gi));
  end

  always_ff @(posedge clk) begin
    data <= rom_mem[addr];
  end

endmodule

// File: rtl/headgen_seq_ctrl.sv
// Header sequencer: walks the microcode ROM one byte per accepted beat and
// presents the word plus latched dynamic fields to the output mux.
module headgen_seq_ctrl
  import headgen_seq_ctrl_pkg::*;
#(
  parameter int HDR_LEN = HDR_LEN_DEF,
  parameter int UADDR_W = UADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [15:0]        dyn0_i,
  input  logic [15:0]        dyn1_i,
  output logic [UADDR_W-1:0] ucode_addr_o,
  input  logic [UWORD_W-1:0] ucode_data_i,
  output logic [UWORD_W-1:0] mux_ucode_o,
  output logic [15:0]        mux_dyn0_o,
  output logic [15:0]        mux_dyn1_o,
  output logic               tvalid_o,
  input  logic               tready_i,
  output logic               tlast_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int IDX_W = $clog2(HDR_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_LEN - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   index_reg;
  logic [UWORD_W-1:0] ucode_hold_reg;
  logic [15:0]        dyn0_reg, dyn1_reg;
  logic               done_reg;

  logic in_send, accept, at_last, start_ok;

  assign in_send  = (state_reg == ST_SEND);
  assign accept   = in_send & tready_i;
  assign at_last  = in_send && (index_reg == LAST_IDX);
  assign start_ok = (state_reg == ST_IDLE) && start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_i) state_next = ST_PRIME;
      ST_PRIME: state_next = ST_SEND;
      ST_SEND:  if (accept && at_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Holding the address on a stall keeps the ROM output on the current word,
  // so during SEND the ROM register itself is the word register: no bubble.
  always_comb begin
    tvalid_o     = in_send;
    tlast_o      = at_last;
    busy_o       = (state_reg != ST_IDLE);
    done_o       = done_reg;
    mux_dyn0_o   = dyn0_reg;
    mux_dyn1_o   = dyn1_reg;
    mux_ucode_o  = in_send ? ucode_data_i : ucode_hold_reg;
    ucode_addr_o = '0;
    if (state_reg != ST_IDLE) begin
      ucode_addr_o = UADDR_W'(index_reg);
      if (accept) ucode_addr_o = UADDR_W'(index_reg) + UADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg      <= '0;
      ucode_hold_reg <= '0;
      dyn0_reg       <= '0;
      dyn1_reg       <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= accept & at_last;
      if (state_reg == ST_PRIME || in_send) ucode_hold_reg <= ucode_data_i;
      if (start_ok) begin
        index_reg <= '0;
        dyn0_reg  <= dyn0_i;
        dyn1_reg  <= dyn1_i;
      end else if (accept) begin
        index_reg <= at_last ? '0 : index_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_headgen_seq_ctrl.sv
// Directed bench: sequencer plus ROM at HDR_LEN 42 and at HDR_LEN 2.
module tb_headgen_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, tready, start2, tready2;
  logic [15:0] d0, d1;
  logic [5:0]  addr, addr2;
  logic [8:0]  udata, udata2, word, word2;
  logic [15:0] md0, md1, md0_2, md1_2;
  logic        tvalid, tlast, busy, done;
  logic        tvalid2, tlast2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  headgen_seq_ctrl #(.HDR_LEN(42), .UADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .dyn0_i(d0), .dyn1_i(d1),
    .ucode_addr_o(addr), .ucode_data_i(udata), .mux_ucode_o(word),
    .mux_dyn0_o(md0), .mux_dyn1_o(md1), .tvalid_o(tvalid), .tready_i(tready),
    .tlast_o(tlast), .busy_o(busy), .done_o(done));
  headgen_ucode_rom #(.UADDR_W(6)) rom (.clk(clk), .addr(addr), .data(udata));

  headgen_seq_ctrl #(.HDR_LEN(2), .UADDR_W(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .dyn0_i(16'h0102), .dyn1_i(16'h0304),
    .ucode_addr_o(addr2), .ucode_data_i(udata2), .mux_ucode_o(word2),
    .mux_dyn0_o(md0_2), .mux_dyn1_o(md1_2), .tvalid_o(tvalid2), .tready_i(tready2),
    .tlast_o(tlast2), .busy_o(busy2), .done_o(done2));
  headgen_ucode_rom #(.UADDR_W(6)) rom2 (.clk(clk), .addr(addr2), .data(udata2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent statement of the ROM contents.
  function automatic logic [31:0] exp_word(input int i);
    if (i >= 12 && i <= 15) return 32'h100 + 32'(i - 12);
    return 32'((i * 5 + 17) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [15:0] a, input logic [15:0] b);
    tick();
    start = 1'b1; d0 = a; d1 = b;
    @(negedge clk);
    chk("start_idle_busy", 32'(busy), 0);
    chk("start_addr", 32'(addr), 0);
    tick();
    start = 1'b0; d0 = 16'h5555; d1 = 16'h6666;
    $display("start dyn0=%h dyn1=%h", a, b);
  endtask

  // Entered at the PRIME cycle; ends after the done cycle.
  task automatic run_frame(input logic [15:0] e0, input logic [15:0] e1, input bit toggle,
                           input bit stray, input bit chain, input logic [15:0] c0,
                           input logic [15:0] c1, input int exp_cycles);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit finished = 1'b0;
    @(negedge clk);
    chk("prime_tvalid", 32'(tvalid), 0);
    chk("prime_busy", 32'(busy), 1);
    chk("prime_dyn0", 32'(md0), 32'(e0));
    chk("prime_dyn1", 32'(md1), 32'(e1));
    while (!finished && cyc < 200) begin
      tick();
      rdy    = toggle ? (cyc % 2 == 0) : 1'b1;
      tready = rdy;
      start  = stray && (idx == 10);
      if (start) d0 = 16'hFFFF;
      @(negedge clk);
      cyc++;
      chk("send_tvalid", 32'(tvalid), 1);
      chk("send_word", 32'(word), exp_word(idx));
      chk("send_tlast", 32'(tlast), (idx == 41) ? 1 : 0);
      chk("send_addr", 32'(addr), rdy ? 32'(idx + 1) : 32'(idx));
      chk("send_dyn0", 32'(md0), 32'(e0));
      chk("send_dyn1", 32'(md1), 32'(e1));
      chk("send_busy", 32'(busy), 1);
      chk("send_done", 32'(done), 0);
      if (rdy) begin
        if (idx == 41) finished = 1'b1;
        else idx++;
      end
    end
    chk("frame_in_budget", 32'(finished), 1);
    chk("frame_cycles", 32'(cyc), 32'(exp_cycles));
    tick();
    start = chain; d0 = c0; d1 = c1;
    @(negedge clk);
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_tvalid", 32'(tvalid), 0);
    chk("end_tlast", 32'(tlast), 0);
    tick();
    start = 1'b0;
    $display("frame dyn0=%h dyn1=%h cycles=%0d chain=%0d", e0, e1, cyc, chain);
    if (!chain) begin
      @(negedge clk);
      chk("post_done", 32'(done), 0);
      chk("post_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; tready = 1'b0; start2 = 1'b0; tready2 = 1'b0;
    d0 = 16'h0; d1 = 16'h0;
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_word", 32'(word), 0);
    chk("rst_dyn0", 32'(md0), 0);
    chk("rst_dyn1", 32'(md1), 0);
    chk("rst_addr", 32'(addr), 0);
    tick();
    rst_n = 1'b1;
    $display("reset released");

    issue_start(16'h1234, 16'hABCD);
    run_frame(16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 42);

    issue_start(16'h1234, 16'hABCD);
    run_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 83);

    issue_start(16'h1234, 16'hABCD);
    run_frame(16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 42);
    run_frame(16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 42);

    // Abort at byte index 20 with an asynchronous reset.
    issue_start(16'h1234, 16'hABCD);
    tready = 1'b1;
    for (int k = 0; k < 21; k++) tick();
    @(negedge clk);
    chk("pre_reset_word", 32'(word), exp_word(20));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(tvalid), 0);
    chk("arst_tlast", 32'(tlast), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_word", 32'(word), 0);
    chk("arst_dyn0", 32'(md0), 0);
    chk("arst_dyn1", 32'(md1), 0);
    chk("arst_addr", 32'(addr), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_rst_done", 32'(done), 0);
      chk("after_rst_busy", 32'(busy), 0);
      chk("after_rst_tvalid", 32'(tvalid), 0);
      tick();
    end
    $display("reset mid-frame checked");
    issue_start(16'h2222, 16'h3333);
    run_frame(16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 42);

    // Minimum header length instance.
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    @(negedge clk);
    chk("h2_prime_tvalid", 32'(tvalid2), 0);
    chk("h2_prime_dyn0", 32'(md0_2), 32'h0102);
    tick();
    tready2 = 1'b1;
    @(negedge clk);
    chk("h2_b0_tvalid", 32'(tvalid2), 1);
    chk("h2_b0_word", 32'(word2), exp_word(0));
    chk("h2_b0_tlast", 32'(tlast2), 0);
    tick();
    @(negedge clk);
    chk("h2_b1_tvalid", 32'(tvalid2), 1);
    chk("h2_b1_word", 32'(word2), exp_word(1));
    chk("h2_b1_tlast", 32'(tlast2), 1);
    tick();
    @(negedge clk);
    chk("h2_done", 32'(done2), 1);
    chk("h2_busy", 32'(busy2), 0);
    tick();
    @(negedge clk);
    chk("h2_done_clear", 32'(done2), 0);
    $display("hdr_len=2 frame checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
